// File: rtl/fll_cfg_pkg.sv
// Shared constants and types for the FLL configuration register slave.
// Register map, CFG field positions and the request-handshake state encoding.
package fll_cfg_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_STATUS   = 2'd0;
  localparam addr_t ADDR_CFG      = 2'd1;
  localparam addr_t ADDR_LOCK_CFG = 2'd2;
  localparam addr_t ADDR_COUNT    = 2'd3;

  localparam int CFG_EN_BIT = 31;
  localparam int LOCK_CFG_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DROP = 2'd2
  } hs_state_e;

endpackage

// File: rtl/fll_cfg_if_if.sv
// FLL request bus between the clock/reset generator (master) and the
// configuration slave: 4-phase req/ack with a registered read-data return.
interface fll_cfg_if_if;
  import fll_cfg_pkg::*;

  logic        fll_req_i;
  logic        fll_wrn_i;
  addr_t       fll_add_i;
  logic [31:0] fll_data_i;
  logic        fll_ack_o;
  logic [31:0] fll_r_data_o;

  modport master (
    output fll_req_i, fll_wrn_i, fll_add_i, fll_data_i,
    input  fll_ack_o, fll_r_data_o
  );

  modport slave (
    input  fll_req_i, fll_wrn_i, fll_add_i, fll_data_i,
    output fll_ack_o, fll_r_data_o
  );

endinterface

// File: rtl/fll_cfg_if_clk_en_div.sv
// Programmable clock-enable divider: cnt runs 0..div and clk_en fires on the
// terminal count. A CFG write restarts the phase so the first pulse is predictable.
module clk_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             cnt_hit,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt;

  assign cnt_hit = (cnt == div);
  assign clk_en  = en & cnt_hit;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr || !en || cnt_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/fll_cfg_if.sv
// FLL configuration register slave: four registers behind a 4-phase req/ack
// handshake, a clock-enable divider, and a lock flag that settles after CFG writes.
module fll_cfg_if
  import fll_cfg_pkg::*;
#(
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_W       = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  fll_cfg_if_if.slave  bus,
  output logic         fll_lock_o,
  output logic         clk_en_o
);

  hs_state_e              state;
  logic                   cfg_en;
  logic [DIV_W-1:0]       cfg_div;
  logic [LOCK_CFG_W-1:0]  lock_cfg;
  logic [LOCK_CFG_W-1:0]  settle;
  logic [31:0]            en_count;

  logic                   access;
  logic                   wr_cfg;
  logic                   wr_lock_cfg;
  logic [31:0]            rd_data;
  logic                   unused_data;
  logic                   unused_cnt_hit;

  // Only the IDLE state accepts a request, so a req still high in DROP is ignored.
  assign access      = (state == IDLE) && bus.fll_req_i;
  assign wr_cfg      = access && !bus.fll_wrn_i && (bus.fll_add_i == ADDR_CFG);
  assign wr_lock_cfg = access && !bus.fll_wrn_i && (bus.fll_add_i == ADDR_LOCK_CFG);
  assign unused_data = ^bus.fll_data_i;

  always_comb begin
    // NOTE: default every output first so no path through the case infers a latch.
    rd_data = '0;
    if (bus.fll_wrn_i) begin
      case (bus.fll_add_i)
        ADDR_STATUS: begin
          rd_data[0] = fll_lock_o;
          rd_data[1] = cfg_en;
        end
        ADDR_CFG: begin
          rd_data[DIV_W-1:0]  = cfg_div;
          rd_data[CFG_EN_BIT] = cfg_en;
        end
        ADDR_LOCK_CFG: rd_data[LOCK_CFG_W-1:0] = lock_cfg;
        default:       rd_data = en_count;
      endcase
    end
  end

  // Handshake FSM with registered ack and read data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state            <= IDLE;
      bus.fll_ack_o    <= 1'b0;
      bus.fll_r_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fll_req_i) begin
            state            <= ACK;
            bus.fll_ack_o    <= 1'b1;
            bus.fll_r_data_o <= rd_data;
          end
        end
        ACK: begin
          if (!bus.fll_req_i) begin
            state            <= DROP;
            bus.fll_ack_o    <= 1'b0;
            bus.fll_r_data_o <= '0;
          end
        end
        DROP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writable registers; STATUS and COUNT writes fall through untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_en   <= 1'b1;
      cfg_div  <= '0;
      lock_cfg <= LOCK_CFG_W'(LOCK_CYCLES);
    end else begin
      if (wr_cfg) begin
        cfg_en  <= bus.fll_data_i[CFG_EN_BIT];
        cfg_div <= bus.fll_data_i[DIV_W-1:0];
      end
      if (wr_lock_cfg) begin
        lock_cfg <= bus.fll_data_i[LOCK_CFG_W-1:0];
      end
    end
  end

  // Settle counter: any CFG write restarts settling, even with identical contents.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      settle     <= LOCK_CFG_W'(LOCK_CYCLES);
      fll_lock_o <= 1'b0;
    end else if (wr_cfg || !cfg_en) begin
      settle     <= lock_cfg;
      fll_lock_o <= 1'b0;
    end else if (settle == '0) begin
      fll_lock_o <= 1'b1;
    end else begin
      settle <= settle - LOCK_CFG_W'(1);
    end
  end

  // A pulse on the same edge as a CFG write still counts; reads see the pre-edge value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_count <= '0;
    end else begin
      en_count <= en_count + 32'(clk_en_o);
    end
  end

  clk_en_div #(
    .DIV_W (DIV_W)
  ) u_clk_en_div (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en      (cfg_en),
    .div     (cfg_div),
    .clr     (wr_cfg),
    .cnt_hit (unused_cnt_hit),
    .clk_en  (clk_en_o)
  );

endmodule

// File: tb/tb_fll_cfg_if.sv
// Bench for fll_cfg_if: directed accesses, a cycle-level behavioural model
// compared every cycle, and literal expectations for the key timing points.
module tb_fll_cfg_if;
  import fll_cfg_pkg::*;

  localparam int LOCK_CYCLES = 16;
  localparam int DIV_W       = 8;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  logic fll_lock_o;
  logic clk_en_o;
  logic cmp_en = 1'b0;

  fll_cfg_if_if bus();

  fll_cfg_if #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .DIV_W       (DIV_W)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .bus        (bus),
    .fll_lock_o (fll_lock_o),
    .clk_en_o   (clk_en_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the divider phase and lock time are derived from the edge index of the
  // last CFG write (reset acts as a CFG write at edge 0 with settle = LOCK_CYCLES).
  int unsigned t, anchor, settle_w, m_div;
  logic        m_en;
  logic [7:0]  m_lock_cfg;
  logic [31:0] m_count;
  int          m_phase;
  logic        m_ack;
  logic [31:0] m_rdata;

  function automatic logic m_clk_en();
    return m_en && (((t - anchor) % (m_div + 1)) == m_div);
  endfunction

  function automatic logic m_lock();
    return m_en && ((t - anchor) > settle_w);
  endfunction

  task automatic model_reset();
    t = 0; anchor = 0; settle_w = LOCK_CYCLES;
    m_en = 1'b1; m_div = 0; m_lock_cfg = 8'(LOCK_CYCLES); m_count = '0;
    m_phase = 0; m_ack = 1'b0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic ce, lk;
    ce = m_clk_en();
    lk = m_lock();
    case (m_phase)
      0: if (bus.fll_req_i) begin
        m_phase = 1;
        m_ack   = 1'b1;
        m_rdata = '0;
        if (bus.fll_wrn_i) begin
          case (bus.fll_add_i)
            2'd0:    m_rdata = {30'd0, m_en, lk};
            2'd1:    m_rdata = {m_en, 23'd0, 8'(m_div)};
            2'd2:    m_rdata = {24'd0, m_lock_cfg};
            default: m_rdata = m_count;
          endcase
        end else if (bus.fll_add_i == 2'd1) begin
          m_en     = bus.fll_data_i[31];
          m_div    = int'(bus.fll_data_i[7:0]);
          anchor   = t + 1;
          settle_w = int'(m_lock_cfg);
        end else if (bus.fll_add_i == 2'd2) begin
          m_lock_cfg = bus.fll_data_i[7:0];
        end
      end
      1: if (!bus.fll_req_i) begin
        m_phase = 2;
        m_ack   = 1'b0;
        m_rdata = '0;
      end
      default: m_phase = 0;
    endcase
    m_count = m_count + 32'(ce);
    t++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rstn_i);
      if (!rstn_i) model_reset();
      else         model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (cmp_en) begin
        check("cyc_ack",    32'(bus.fll_ack_o), 32'(m_ack));
        check("cyc_rdata",  bus.fll_r_data_o,   m_rdata);
        check("cyc_lock",   32'(fll_lock_o),    32'(m_lock()));
        check("cyc_clk_en", 32'(clk_en_o),      32'(m_clk_en()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic access(input logic wrn, input addr_t add, input logic [31:0] data,
                        output logic [31:0] rd);
    bit got;
    got = 1'b0;
    bus.fll_wrn_i  = wrn;
    bus.fll_add_i  = add;
    bus.fll_data_i = data;
    bus.fll_req_i  = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_i);
      got = bus.fll_ack_o;
    end
    check("ack_seen", 32'(got), 32'd1);
    rd = bus.fll_r_data_o;
  endtask

  task automatic release_bus();
    bus.fll_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  logic [31:0] rd, c1, c2, c3;
  int          n_ack, n_extra;

  initial begin
    bus.fll_req_i  = 1'b0;
    bus.fll_wrn_i  = 1'b1;
    bus.fll_add_i  = ADDR_STATUS;
    bus.fll_data_i = '0;
    cmp_en         = 1'b1;

    // Reset values, then lock after 17 cycles.
    repeat (3) @(negedge clk_i);
    check("rst_ack",    32'(bus.fll_ack_o), 32'd0);
    check("rst_rdata",  bus.fll_r_data_o,   32'd0);
    check("rst_lock",   32'(fll_lock_o),    32'd0);
    check("rst_clk_en", 32'(clk_en_o),      32'd1);
    rstn_i = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk_i);
      check("rst_settle_lock", 32'(fll_lock_o), 32'(i >= 17));
    end
    access(1'b1, ADDR_COUNT, '0, rd);
    check("count_ge_17", 32'(rd >= 32'd17), 32'd1);
    release_bus();

    // Divide by 4 and 17-cycle relock.
    access(1'b0, ADDR_CFG, 32'h8000_0003, rd);
    check("write_rdata_zero", rd, 32'd0);
    bus.fll_req_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      check("div4_clk_en", 32'(clk_en_o),   32'((i % 4) == 3));
      check("div4_lock",   32'(fll_lock_o), 32'(i >= 17));
      @(negedge clk_i);
    end
    access(1'b1, ADDR_STATUS, '0, rd);
    check("status_lock_en", rd, 32'h0000_0003);
    release_bus();
    access(1'b1, ADDR_CFG, '0, rd);
    check("cfg_readback", rd, 32'h8000_0003);
    release_bus();

    // Zero settle: lock one edge after the CFG write edge.
    access(1'b0, ADDR_LOCK_CFG, 32'h0000_0000, rd);
    release_bus();
    check("lock_cfg_wr_keeps_lock", 32'(fll_lock_o), 32'd1);
    access(1'b0, ADDR_CFG, 32'h8000_0000, rd);
    check("zero_settle_lock_low", 32'(fll_lock_o), 32'd0);
    bus.fll_req_i = 1'b0;
    @(negedge clk_i);
    check("zero_settle_lock_high", 32'(fll_lock_o), 32'd1);
    @(negedge clk_i);
    access(1'b1, ADDR_LOCK_CFG, '0, rd);
    check("lock_cfg_readback", rd, 32'h0000_0000);
    release_bus();

    // Disable: no pulses, no lock, COUNT frozen.
    access(1'b0, ADDR_CFG, 32'h0000_0005, rd);
    release_bus();
    check("disabled_clk_en", 32'(clk_en_o),   32'd0);
    check("disabled_lock",   32'(fll_lock_o), 32'd0);
    access(1'b1, ADDR_COUNT, '0, c1);
    release_bus();
    repeat (50) @(negedge clk_i);
    access(1'b1, ADDR_COUNT, '0, c2);
    release_bus();
    check("count_frozen", c2, c1);
    check("disabled_lock_late", 32'(fll_lock_o), 32'd0);

    // Write to COUNT is ignored but acknowledged.
    access(1'b0, ADDR_COUNT, 32'hFFFF_FFFF, rd);
    release_bus();
    access(1'b1, ADDR_COUNT, '0, c3);
    release_bus();
    check("count_write_ignored", c3, c1);

    // Long req: one access, ack held while req is high.
    bus.fll_wrn_i = 1'b1;
    bus.fll_add_i = ADDR_STATUS;
    bus.fll_req_i = 1'b1;
    n_ack = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (bus.fll_ack_o) n_ack++;
    end
    bus.fll_req_i = 1'b0;
    n_extra = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (bus.fll_ack_o) n_extra++;
    end
    check("hold_ack_cycles", 32'(n_ack), 32'd10);
    check("hold_single_access", 32'(n_extra), 32'd0);

    // Req re-raised during DROP is not taken until IDLE.
    access(1'b1, ADDR_LOCK_CFG, '0, rd);
    bus.fll_req_i = 1'b0;
    @(negedge clk_i);
    bus.fll_req_i = 1'b1;
    @(negedge clk_i);
    check("drop_ignores_req", 32'(bus.fll_ack_o), 32'd0);
    @(negedge clk_i);
    check("req_after_drop_acked", 32'(bus.fll_ack_o), 32'd1);
    release_bus();

    // Asynchronous reset during ACK, then a fresh access with reset-value data.
    access(1'b1, ADDR_CFG, '0, rd);
    check("cfg_disabled_readback", rd, 32'h0000_0005);
    #2 rstn_i = 1'b0;
    #1;
    check("async_ack_drop",   32'(bus.fll_ack_o), 32'd0);
    check("async_rdata_drop", bus.fll_r_data_o,   32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_ack",   32'(bus.fll_ack_o), 32'd1);
    check("post_rst_rdata", bus.fll_r_data_o,   32'h8000_0000);
    release_bus();

    repeat (3) @(negedge clk_i);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
